// File: rtl/guvm_wb_pkg.sv
// Shared types for the GUVM Wishbone responder: FSM states, response kinds
// and the capture record layout used at the default bus widths.
package guvm_wb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        STALL,
        RESP
    } state_t;

    typedef enum logic {
        ACK,
        ERR
    } resp_t;

    localparam int CAP_ADR_W = 32;
    localparam int CAP_DAT_W = 32;
    localparam int CAP_SEL_W = CAP_DAT_W / 8;

    // Field order matches the packed capture word {adr, dat, sel} held in the
    // capture FIFO, so a default-width capture word maps onto this record.
    typedef struct packed {
        logic [CAP_ADR_W-1:0] adr;
        logic [CAP_DAT_W-1:0] dat;
        logic [CAP_SEL_W-1:0] sel;
    } cap_rec_t;

endpackage

// File: rtl/guvm_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes when full and pops when
// empty are ignored, and a push and pop in the same cycle are both honoured.
module guvm_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           push,
    input  logic [WIDTH-1:0]               wdata,
    input  logic                           pop,
    output logic [WIDTH-1:0]               rdata,
    output logic                           full,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage array needs no reset: only entries between the pointers are visible.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/guvm_wb_responder.sv
// Wishbone slave responder: serves read beats from preloaded lines, captures
// write beats, and adds wait states, error injection and a stall timeout.
module guvm_wb_responder
    import guvm_wb_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int LINE_WORDS  = 4,
    parameter int LINE_DEPTH  = 8,
    parameter int CAP_DEPTH   = 8,
    parameter int WAIT_STATES = 0,
    parameter int TIMEOUT     = 64
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [ADDR_W-1:0]            i_wb_adr,
    input  logic [DATA_W-1:0]            i_wb_dat,
    input  logic [DATA_W/8-1:0]          i_wb_sel,
    input  logic                         i_wb_we,
    input  logic                         i_wb_cyc,
    input  logic                         i_wb_stb,
    output logic [DATA_W-1:0]            o_wb_dat,
    output logic                         o_wb_ack,
    output logic                         o_wb_err,
    input  logic                         i_ld_valid,
    input  logic [LINE_WORDS*DATA_W-1:0] i_ld_line,
    output logic                         o_ld_ready,
    output logic                         o_cap_valid,
    output logic [ADDR_W-1:0]            o_cap_adr,
    output logic [DATA_W-1:0]            o_cap_dat,
    output logic [DATA_W/8-1:0]          o_cap_sel,
    input  logic                         i_cap_ready,
    input  logic                         i_err_inject,
    output logic                         o_timeout
);

    localparam int SEL_W     = DATA_W / 8;
    localparam int LINE_W    = LINE_WORDS * DATA_W;
    localparam int CAP_W     = ADDR_W + DATA_W + SEL_W;
    localparam int IDX_W     = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
    localparam int WAIT_W    = 4;
    localparam int WAIT_LOAD = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam int STALL_W   = $clog2(TIMEOUT + 1);
    localparam int LCNT_W    = $clog2(LINE_DEPTH + 1);
    localparam int CCNT_W    = $clog2(CAP_DEPTH + 1);

    state_t              state_q;
    state_t              state_d;
    resp_t               resp_q;
    logic [WAIT_W-1:0]   wait_cnt_q;
    logic [STALL_W-1:0]  stall_cnt_q;
    logic                err_armed_q;
    logic                timeout_q;
    logic                touched_q;
    logic                cyc_q;
    logic [DATA_W-1:0]   dat_q;

    logic [ADDR_W-1:0]   beat_adr_q;
    logic [DATA_W-1:0]   beat_dat_q;
    logic [SEL_W-1:0]    beat_sel_q;
    logic                beat_we_q;

    logic [ADDR_W-1:0]   cur_adr;
    logic [DATA_W-1:0]   cur_dat;
    logic [SEL_W-1:0]    cur_sel;
    logic                cur_we;
    logic [IDX_W-1:0]    cur_idx;
    logic                cur_last;

    logic                beat_req;
    logic                can_serve;
    logic                issue_ack;
    logic                issue_err;
    logic                set_timeout;
    logic                issue_rd;
    logic                cyc_fall;

    logic [LINE_W-1:0]   line_head;
    logic                line_full;
    logic                line_empty;
    logic [LCNT_W-1:0]   line_count;
    logic                line_pop;

    logic [CAP_W-1:0]    cap_in;
    logic [CAP_W-1:0]    cap_out;
    logic                cap_full;
    logic                cap_empty;
    logic [CCNT_W-1:0]   cap_count;
    logic                cap_push;
    logic                cap_pop;

    // In IDLE the beat is evaluated straight off the bus; later it uses the sampled copy.
    assign beat_req = i_wb_cyc && i_wb_stb;
    assign cur_adr  = (state_q == IDLE) ? i_wb_adr : beat_adr_q;
    assign cur_dat  = (state_q == IDLE) ? i_wb_dat : beat_dat_q;
    assign cur_sel  = (state_q == IDLE) ? i_wb_sel : beat_sel_q;
    assign cur_we   = (state_q == IDLE) ? i_wb_we  : beat_we_q;
    assign cur_idx  = IDX_W'(cur_adr >> 2) & IDX_W'(LINE_WORDS - 1);
    assign cur_last = (cur_idx == IDX_W'(LINE_WORDS - 1));

    assign can_serve = cur_we ? !cap_full : !line_empty;
    assign issue_rd  = issue_ack && !cur_we;
    assign cyc_fall  = cyc_q && !i_wb_cyc;

    // A line retires on the last-word read, or when the core ends its cycle after partial use.
    assign line_pop = (issue_rd && cur_last) || (cyc_fall && touched_q && (line_count != '0));
    assign cap_push = issue_ack && cur_we;
    assign cap_pop  = i_cap_ready && (cap_count != '0);
    assign cap_in   = {cur_adr, cur_dat, cur_sel};

    assign o_ld_ready  = !line_full;
    assign o_cap_valid = !cap_empty;
    assign o_cap_adr   = cap_out[CAP_W-1 -: ADDR_W];
    assign o_cap_dat   = cap_out[SEL_W +: DATA_W];
    assign o_cap_sel   = cap_out[SEL_W-1:0];
    assign o_wb_dat    = dat_q;
    assign o_timeout   = timeout_q;

    guvm_sync_fifo #(
        .WIDTH (LINE_W),
        .DEPTH (LINE_DEPTH)
    ) u_line_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (i_ld_valid),
        .wdata (i_ld_line),
        .pop   (line_pop),
        .rdata (line_head),
        .full  (line_full),
        .empty (line_empty),
        .count (line_count)
    );

    guvm_sync_fifo #(
        .WIDTH (CAP_W),
        .DEPTH (CAP_DEPTH)
    ) u_cap_fifo (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .push  (cap_push),
        .wdata (cap_in),
        .pop   (cap_pop),
        .rdata (cap_out),
        .full  (cap_full),
        .empty (cap_empty),
        .count (cap_count)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an armed error wins, then service, then stall until timeout.
    always_comb begin
        logic do_eval;
        state_d     = state_q;
        issue_ack   = 1'b0;
        issue_err   = 1'b0;
        set_timeout = 1'b0;
        do_eval     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (beat_req) begin
                    if (WAIT_STATES > 0) begin
                        state_d = WAIT;
                    end else begin
                        do_eval = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else if (wait_cnt_q == '0) begin
                    do_eval = 1'b1;
                end
            end
            STALL: begin
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                end else begin
                    do_eval = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (do_eval) begin
            if (err_armed_q) begin
                state_d   = RESP;
                issue_err = 1'b1;
            end else if (can_serve) begin
                state_d   = RESP;
                issue_ack = 1'b1;
            end else if (state_q == STALL && stall_cnt_q == STALL_W'(TIMEOUT - 1)) begin
                state_d     = RESP;
                issue_err   = 1'b1;
                set_timeout = 1'b1;
            end else begin
                state_d = STALL;
            end
        end
    end

    // Ack/err are driven only while in RESP, so each lasts exactly one registered cycle.
    always_comb begin
        o_wb_ack = 1'b0;
        o_wb_err = 1'b0;
        if (state_q == RESP) begin
            o_wb_ack = (resp_q == ACK);
            o_wb_err = (resp_q == ERR);
        end
    end

    // Wait-state and stall counters reload whenever their state is not active.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (state_q != WAIT) begin
                wait_cnt_q <= WAIT_W'(WAIT_LOAD);
            end else if (wait_cnt_q != '0) begin
                wait_cnt_q <= wait_cnt_q - 1'b1;
            end
            if (state_q != STALL) begin
                stall_cnt_q <= '0;
            end else begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
        end
    end

    // Beat sampling, response kind, read data and the sticky timeout flag.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            beat_adr_q <= '0;
            beat_dat_q <= '0;
            beat_sel_q <= '0;
            beat_we_q  <= 1'b0;
            resp_q     <= ACK;
            dat_q      <= '0;
            timeout_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && beat_req) begin
                beat_adr_q <= i_wb_adr;
                beat_dat_q <= i_wb_dat;
                beat_sel_q <= i_wb_sel;
                beat_we_q  <= i_wb_we;
            end
            if (issue_ack || issue_err) begin
                resp_q <= issue_err ? ERR : ACK;
            end
            if (issue_rd) begin
                dat_q <= line_head[cur_idx*DATA_W +: DATA_W];
            end
            if (set_timeout) begin
                timeout_q <= 1'b1;
            end
        end
    end

    // Error arm, line-touched flag and cyc history for end-of-cycle line retirement.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_armed_q <= 1'b0;
            touched_q   <= 1'b0;
            cyc_q       <= 1'b0;
        end else begin
            cyc_q <= i_wb_cyc;
            if (issue_err) begin
                err_armed_q <= i_err_inject;
            end else if (i_err_inject) begin
                err_armed_q <= 1'b1;
            end
            if (line_pop) begin
                touched_q <= 1'b0;
            end else if (issue_rd) begin
                touched_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_guvm_wb_responder.sv
// Directed bench for guvm_wb_responder: a zero-wait-state instance for the
// read/write/error paths and a three-wait-state instance for starvation,
// timeout and reset-during-beat behaviour.
module tb_guvm_wb_responder;
    import guvm_wb_pkg::*;

    typedef struct {
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    localparam logic [127:0] LINE1 = 128'hF0801003_F0801003_F0801003_F0800003;
    localparam logic [127:0] LINE2 = 128'h44444444_33333333_22222222_11111111;
    localparam logic [127:0] LINE3 = 128'hDDDD0003_CCCC0002_BBBB0001_AAAA0000;
    localparam logic [127:0] LINEB = 128'h5B5B0003_5B5B0002_5B5B0001_5B5B0000;
    localparam logic [127:0] LINEC = 128'h6C6C0003_6C6C0002_6C6C0001_6C6C0000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  adr;
    logic [31:0]  wdat;
    logic [3:0]   sel;
    logic         we;
    logic         stb;
    logic [127:0] ld_line;
    logic         cap_ready;
    logic         cyc_a, cyc_b, ld_valid_a, ld_valid_b, inj_a, inj_b;

    logic [31:0]  dat_a, dat_b, cap_adr_a, cap_adr_b, cap_dat_a, cap_dat_b;
    logic [3:0]   cap_sel_a, cap_sel_b;
    logic         ack_a, ack_b, err_a, err_b, ld_ready_a, ld_ready_b;
    logic         cap_valid_a, cap_valid_b, timeout_a, timeout_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    guvm_wb_responder #(.WAIT_STATES(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_cyc(cyc_a), .i_wb_stb(stb),
        .o_wb_dat(dat_a), .o_wb_ack(ack_a), .o_wb_err(err_a),
        .i_ld_valid(ld_valid_a), .i_ld_line(ld_line), .o_ld_ready(ld_ready_a),
        .o_cap_valid(cap_valid_a), .o_cap_adr(cap_adr_a), .o_cap_dat(cap_dat_a),
        .o_cap_sel(cap_sel_a), .i_cap_ready(cap_ready),
        .i_err_inject(inj_a), .o_timeout(timeout_a)
    );

    guvm_wb_responder #(.WAIT_STATES(3)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_wb_adr(adr), .i_wb_dat(wdat), .i_wb_sel(sel), .i_wb_we(we),
        .i_wb_cyc(cyc_b), .i_wb_stb(stb),
        .o_wb_dat(dat_b), .o_wb_ack(ack_b), .o_wb_err(err_b),
        .i_ld_valid(ld_valid_b), .i_ld_line(ld_line), .o_ld_ready(ld_ready_b),
        .o_cap_valid(cap_valid_b), .o_cap_adr(cap_adr_b), .o_cap_dat(cap_dat_b),
        .o_cap_sel(cap_sel_b), .i_cap_ready(cap_ready),
        .i_err_inject(inj_b), .o_timeout(timeout_b)
    );

    // Compare one value and report a mismatch.
    task automatic checkOutput(input string name, input logic [71:0] act, input logic [71:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // Wait a bounded number of cycles for ack or err from the selected instance.
    task automatic waitResponse(input bit use_b, input int limit, output logic r_ack,
                                output logic r_err, output logic [31:0] r_dat, output int lat);
        r_ack = 1'b0;
        r_err = 1'b0;
        r_dat = '0;
        lat   = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            lat++;
            if (use_b ? (ack_b || err_b) : (ack_a || err_a)) begin
                r_ack = use_b ? ack_b : ack_a;
                r_err = use_b ? err_b : err_a;
                r_dat = use_b ? dat_b : dat_a;
                break;
            end
        end
        stb = 1'b0;
        we  = 1'b0;
        if (!(r_ack || r_err)) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL response_wait: actual none after %0d cycles required ack or err", limit);
        end
    endtask

    // Drive one beat and collect its response.
    task automatic applyStimulus(input bit use_b, input logic wr, input logic [31:0] a,
                                 input logic [31:0] d, input logic [3:0] s,
                                 output logic r_ack, output logic r_err,
                                 output logic [31:0] r_dat, output int lat);
        @(negedge clk);
        we   = wr;
        adr  = a;
        wdat = d;
        sel  = s;
        stb  = 1'b1;
        waitResponse(use_b, 200, r_ack, r_err, r_dat, lat);
    endtask

    // Push one line into the selected instance.
    task automatic pushLine(input bit use_b, input logic [127:0] line);
        @(negedge clk);
        ld_line = line;
        if (use_b) ld_valid_b = 1'b1; else ld_valid_a = 1'b1;
        @(negedge clk);
        ld_valid_a = 1'b0;
        ld_valid_b = 1'b0;
    endtask

    // Pulse cap_ready for one cycle.
    task automatic popCapture();
        @(negedge clk);
        cap_ready = 1'b1;
        @(negedge clk);
        cap_ready = 1'b0;
    endtask

    // Hard stop if something hangs outside the bounded waits.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: actual still running required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t        vecs[8];
        logic        r_ack, r_err, saw;
        logic [31:0] r_dat;
        int          lat;
        cap_rec_t    exp_cap;

        vecs[0] = '{1'b0, 32'h0,   32'h0, 4'hF, 1'b0, 32'hF0800003, 1};
        vecs[1] = '{1'b0, 32'h0,   32'h0, 4'hF, 1'b0, 32'hF0800003, 1};
        vecs[2] = '{1'b0, 32'h4,   32'h0, 4'hF, 1'b0, 32'hF0801003, 1};
        vecs[3] = '{1'b0, 32'h8,   32'h0, 4'hF, 1'b0, 32'hF0801003, 1};
        vecs[4] = '{1'b0, 32'hC,   32'h0, 4'hF, 1'b0, 32'hF0801003, 1};
        vecs[5] = '{1'b0, 32'h0,   32'h0, 4'hF, 1'b0, 32'h11111111, 1};
        vecs[6] = '{1'b0, 32'h8,   32'h0, 4'hF, 1'b0, 32'h33333333, 1};
        vecs[7] = '{1'b1, 32'h100, 32'h5, 4'hF, 1'b0, 32'h33333333, 1};

        rst_n = 1'b0;
        adr = '0; wdat = '0; sel = '0; we = 1'b0; stb = 1'b0;
        ld_line = '0; cap_ready = 1'b0;
        cyc_a = 1'b0; cyc_b = 1'b0; ld_valid_a = 1'b0; ld_valid_b = 1'b0;
        inj_a = 1'b0; inj_b = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ack", ack_a, 1'b0);
        checkOutput("rst_err", err_a, 1'b0);
        checkOutput("rst_dat", dat_a, 32'h0);
        checkOutput("rst_ld_ready", ld_ready_a, 1'b1);
        checkOutput("rst_cap_valid", cap_valid_a, 1'b0);
        checkOutput("rst_timeout", timeout_a, 1'b0);
        rst_n = 1'b1;

        pushLine(1'b0, LINE1);
        pushLine(1'b0, LINE2);

        @(negedge clk);
        cyc_a = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
                          r_ack, r_err, r_dat, lat);
            checkOutput($sformatf("vec%0d_ack", i), r_ack, !vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_err", i), r_err, vecs[i].exp_err);
            checkOutput($sformatf("vec%0d_rdata", i), r_dat, vecs[i].exp_rdata);
            checkOutput($sformatf("vec%0d_latency", i), 72'(lat), 72'(vecs[i].exp_lat));
        end
        checkOutput("burst_ld_ready", ld_ready_a, 1'b1);

        exp_cap = '{adr: 32'h100, dat: 32'h5, sel: 4'hF};
        checkOutput("cap_valid_after_write", cap_valid_a, 1'b1);
        checkOutput("cap_record", {cap_adr_a, cap_dat_a, cap_sel_a}, exp_cap);
        popCapture();
        checkOutput("cap_valid_after_pop", cap_valid_a, 1'b0);

        // Dropping cyc retires the partially read LINE2; LINE3 must be the head next.
        @(negedge clk);
        cyc_a = 1'b0;
        pushLine(1'b0, LINE3);
        cyc_a = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h4, 32'h0, 4'hF, r_ack, r_err, r_dat, lat);
        checkOutput("cycfall_pop_rdata", r_dat, 32'hBBBB0001);
        applyStimulus(1'b0, 1'b0, 32'hC, 32'h0, 4'hF, r_ack, r_err, r_dat, lat);
        checkOutput("line3_last_rdata", r_dat, 32'hDDDD0003);

        // Injected error on a write: one err cycle, no capture, then normal service.
        @(negedge clk);
        inj_a = 1'b1;
        @(negedge clk);
        inj_a = 1'b0;
        applyStimulus(1'b0, 1'b1, 32'h200, 32'h77, 4'h3, r_ack, r_err, r_dat, lat);
        checkOutput("inject_err", r_err, 1'b1);
        checkOutput("inject_ack", r_ack, 1'b0);
        @(negedge clk);
        checkOutput("inject_err_one_cycle", err_a, 1'b0);
        checkOutput("inject_no_capture", cap_valid_a, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h204, 32'h88, 4'hC, r_ack, r_err, r_dat, lat);
        checkOutput("post_inject_ack", r_ack, 1'b1);
        exp_cap = '{adr: 32'h204, dat: 32'h88, sel: 4'hC};
        checkOutput("post_inject_cap", {cap_adr_a, cap_dat_a, cap_sel_a}, exp_cap);
        popCapture();
        cyc_a = 1'b0;

        // Wait states plus starvation: no answer while empty, ack once a line arrives.
        @(negedge clk);
        cyc_b = 1'b1;
        we = 1'b0; adr = 32'h0; sel = 4'hF; stb = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (ack_b || err_b) saw = 1'b1;
        end
        checkOutput("starved_no_response", saw, 1'b0);
        ld_line = LINEB;
        ld_valid_b = 1'b1;
        @(negedge clk);
        ld_valid_b = 1'b0;
        waitResponse(1'b1, 20, r_ack, r_err, r_dat, lat);
        checkOutput("starved_then_ack", r_ack, 1'b1);
        checkOutput("starved_rdata", r_dat, 32'h5B5B0000);
        checkOutput("starved_no_timeout", timeout_b, 1'b0);
        @(negedge clk);
        cyc_b = 1'b0;

        // Stall timeout: err after 1 + WAIT_STATES + TIMEOUT cycles, sticky flag.
        @(negedge clk);
        cyc_b = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h4, 32'h0, 4'hF, r_ack, r_err, r_dat, lat);
        checkOutput("timeout_err", r_err, 1'b1);
        checkOutput("timeout_latency", 72'(lat), 72'(68));
        checkOutput("timeout_rdata_held", r_dat, 32'h5B5B0000);
        repeat (3) @(negedge clk);
        checkOutput("timeout_sticky", timeout_b, 1'b1);
        cyc_b = 1'b0;

        // Reset asserted during WAIT with two lines queued.
        pushLine(1'b1, LINEB);
        pushLine(1'b1, LINEC);
        @(negedge clk);
        cyc_b = 1'b1;
        we = 1'b0; adr = 32'h0; stb = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_ack", ack_b, 1'b0);
        checkOutput("midrst_err", err_b, 1'b0);
        checkOutput("midrst_ld_ready", ld_ready_b, 1'b1);
        checkOutput("midrst_timeout", timeout_b, 1'b0);
        checkOutput("midrst_dat", dat_b, 32'h0);
        @(negedge clk);
        stb = 1'b0;
        cyc_b = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Queued lines must be gone: a read stalls, then cyc drop aborts silently.
        @(negedge clk);
        cyc_b = 1'b1;
        we = 1'b0; adr = 32'h0; stb = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ack_b || err_b) saw = 1'b1;
        end
        cyc_b = 1'b0;
        stb = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (ack_b || err_b) saw = 1'b1;
        end
        checkOutput("postrst_fifo_empty_and_abort", saw, 1'b0);

        // FSM is back in IDLE: a fresh read takes exactly 1 + WAIT_STATES cycles.
        pushLine(1'b1, LINEC);
        cyc_b = 1'b1;
        applyStimulus(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, r_ack, r_err, r_dat, lat);
        checkOutput("postrst_ack", r_ack, 1'b1);
        checkOutput("postrst_latency", 72'(lat), 72'(4));
        checkOutput("postrst_rdata", r_dat, 32'h6C6C0002);
        @(negedge clk);
        cyc_b = 1'b0;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
